multdiv_stage: RTL

Iterative multiply/divide unit for the execute stage of the 5-stage pipeline. It consumes the DX-latch instruction and the post-bypass ALU A/B operands, then freezes PC/FD/DX while it iterates. It hands a completed result, destination register and error flag to the XM latch, where the error flag feeds the XM error-flag latch used by exception forwarding.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/multdiv_datapath.sv | 95 +++++++++
 rtl/multdiv_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: instruction field encodings, special registers and the
// multiply/divide unit state type.
package pipeline_pkg;

  localparam logic [4:0] OP_ALU      = 5'd0;
  localparam logic [4:0] ALU_MUL     = 5'd6;
  localparam logic [4:0] ALU_DIV     = 5'd7;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, with the
// iteration counter and the final sign fix-up / overflow detection.
module multdiv_datapath #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_div,
  input  logic              step,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              last,
  output logic [DATA_W-1:0] result,
  output logic              exception
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  logic [CNT_W-1:0]    cnt_q;
  logic                op_div_q, neg_q, exc_q;
  logic [2*DATA_W-1:0] acc_q, mcand_q;
  logic [DATA_W-1:0]   mplier_q, rem_q, quot_q, dvsr_q, result_q;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] acc_nx, prod_fix;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W-1:0]   diff, rem_nx, quot_nx, quot_fix;
  logic                ge, ovf;

  always_comb begin
    a_mag    = operand_a[DATA_W-1] ? -operand_a : operand_a;
    b_mag    = operand_b[DATA_W-1] ? -operand_b : operand_b;
    acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh   = {rem_q, quot_q[DATA_W-1]};
    ge       = rem_sh >= {1'b0, dvsr_q};
    diff     = rem_sh[DATA_W-1:0] - dvsr_q;
    rem_nx   = ge ? diff : rem_sh[DATA_W-1:0];
    quot_nx  = {quot_q[DATA_W-2:0], ge};
    prod_fix = neg_q ? -acc_nx : acc_nx;
    quot_fix = neg_q ? -quot_nx : quot_nx;
    // Signed product must be the sign extension of its low word.
    ovf      = prod_fix[2*DATA_W-1:DATA_W-1] != {(DATA_W + 1){prod_fix[DATA_W-1]}};
  end

  assign last      = cnt_q == CNT_W'(ITER - 1);
  assign result    = result_q;
  assign exception = exc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      exc_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      op_div_q <= start_div;
      neg_q    <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, a_mag};
      mplier_q <= b_mag;
      rem_q    <= '0;
      quot_q   <= a_mag;
      dvsr_q   <= b_mag;
      if (start_div && operand_b == '0) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (op_div_q) begin
        rem_q  <= rem_nx;
        quot_q <= quot_nx;
      end else begin
        acc_q    <= acc_nx;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (last) begin
        result_q <= op_div_q ? quot_fix : prod_fix[DATA_W-1:0];
        exc_q    <= op_div_q ? 1'b0 : ovf;
      end
    end
  end

endmodule

// File: rtl/multdiv_stage.sv
// Execute-stage multiply/divide unit: decodes the DX instruction, stalls the front of the
// pipeline while iterating and presents a one-cycle result pulse to the XM latch.
module multdiv_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       dx_instr,
  input  logic              dx_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        result_rd,
  output logic              exception
);

  md_state_t  state_q, state_d;
  logic [4:0] rd_q;
  logic       valid_q;
  logic       md_op, start, start_div, step, last;
  logic       unused_instr;

  assign unused_instr = ^{dx_instr[21:7], dx_instr[1:0]};

  assign md_op     = dx_valid && dx_instr[31:27] == OP_ALU &&
                     (dx_instr[6:2] == ALU_MUL || dx_instr[6:2] == ALU_DIV);
  assign start     = state_q == MD_IDLE && md_op && !flush;
  assign start_div = dx_instr[6:2] == ALU_DIV;
  assign step      = (state_q == MD_MUL || state_q == MD_DIV) && !flush;

  // Gated by reset so the pipeline is released the moment reset asserts.
  assign stall = reset_n && (start || state_q == MD_MUL || state_q == MD_DIV);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (!start_div)           state_d = MD_MUL;
          else if (operand_b == '0) state_d = MD_DONE;
          else                      state_d = MD_DIV;
        end
      end
      MD_MUL, MD_DIV: begin
        if (flush)     state_d = MD_IDLE;
        else if (last) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= state_d == MD_DONE;
      if (start) rd_q <= dx_instr[26:22];
    end
  end

  assign result_valid = valid_q;
  assign result_rd    = rd_q;

  multdiv_datapath #(
    .DATA_W (DATA_W),
    .ITER   (ITER)
  ) u_datapath (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .start_div (start_div),
    .step      (step),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .last      (last),
    .result    (result),
    .exception (exception)
  );

endmodule
